// File: rtl/apb_reg_slave_pkg.sv
// Shared APB slave types: FSM states, captured-request record and register-map constants.
// Pure declarations, no timing or handshake of its own.
package apb_reg_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
  } apb_req_t;

  localparam logic [7:0] WAITCFG_ADDR  = 8'h0F;
  localparam int         NUM_DATA_REGS = 15;

  function automatic logic is_mapped(input logic [7:0] a);
    return a <= WAITCFG_ADDR;
  endfunction

endpackage

// File: rtl/apb_reg_slave_wait_counter.sv
// 3-bit wait-state counter: load has priority, decrement saturates at zero.
// Zero flag is combinational from the register; load/decrement land one cycle later.
module apb_wait_counter (
  input  logic       core_clk_i,
  input  logic       arst_n_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic [2:0] cnt_o,
  output logic       zero_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge core_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: 15 data registers plus WAITCFG, which sets N wait states per transfer.
// ready rises N+1 access cycles after SETUP; the master is held until then, sel loss before ready aborts.
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter logic [1:0] SLV_ID   = 2'd1,
  parameter logic [2:0] WAIT_RST = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       enable,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       err
);

  apb_state_e state_q, state_d;
  apb_req_t   req_q, req_d;
  logic [7:0] regs_q [NUM_DATA_REGS];
  logic [2:0] waitcfg_q;

  logic       selected;
  logic       setup_req;
  logic       commit;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic [2:0] cnt_val;
  logic [2:0] wait_load;

  assign selected  = (sel == SLV_ID);
  assign setup_req = selected && !enable;

  // A WAITCFG write completing in the same cycle as a back-to-back SETUP feeds that SETUP.
  assign wait_load = (commit && (req_q.addr == WAITCFG_ADDR)) ? req_q.wdata[2:0] : waitcfg_q;

  apb_wait_counter u_wait_counter (
    .core_clk_i (clk),
    .arst_n_i   (reset),
    .load_i     (cnt_load),
    .load_val_i (wait_load),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    commit   = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    rdata    = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (setup_req) begin
          state_d  = SETUP;
          req_d    = '{addr: addr, wr: write, wdata: wdata};
          cnt_load = 1'b1;
        end
      end
      SETUP: begin
        if (!selected) begin
          state_d = IDLE;
        end else if (enable) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          ready  = 1'b1;
          err    = !is_mapped(req_q.addr);
          commit = req_q.wr && is_mapped(req_q.addr);
          if (!req_q.wr && is_mapped(req_q.addr)) begin
            rdata = (req_q.addr == WAITCFG_ADDR) ? {5'b0, waitcfg_q} : regs_q[req_q.addr[3:0]];
          end
          if (setup_req) begin
            state_d  = SETUP;
            req_d    = '{addr: addr, wr: write, wdata: wdata};
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!selected) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DATA_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      waitcfg_q <= WAIT_RST;
    end else if (commit) begin
      if (req_q.addr == WAITCFG_ADDR) begin
        waitcfg_q <= req_q.wdata[2:0];
      end else begin
        regs_q[req_q.addr[3:0]] <= req_q.wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: directed scenarios with literal expectations, then random traffic,
// all outputs checked every cycle against a transaction-level model of the register map.
module tb_apb_reg_slave;
  import apb_reg_slave_pkg::*;

  localparam logic [1:0] ID = 2'd1;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic [1:0] sel    = 2'd0;
  logic       enable = 1'b0;
  logic       write  = 1'b0;
  logic [7:0] addr   = 8'h00;
  logic [7:0] wdata  = 8'h00;
  logic [7:0] rdata;
  logic       ready;
  logic       err;

  int checks = 0;
  int errors = 0;

  apb_reg_slave #(.SLV_ID(ID), .WAIT_RST(3'd0)) dut (
    .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 15 of m_regs holds the wait count N (upper bits always zero).
  logic [7:0] m_regs [16] = '{default: 8'h00};
  bit         m_setup  = 1'b0;
  bit         m_access = 1'b0;
  int         m_waits  = 0;
  logic [7:0] m_addr   = 8'h00;
  logic [7:0] m_wdata  = 8'h00;
  bit         m_wr     = 1'b0;

  function automatic void m_reset();
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_setup = 1'b0; m_access = 1'b0; m_waits = 0;
  endfunction

  function automatic void m_begin();
    m_setup = 1'b1; m_addr = addr; m_wr = write; m_wdata = wdata;
    m_waits = int'(m_regs[15]);
  endfunction

  function automatic void m_step();
    bit on = (sel == ID);
    if (m_access) begin
      if (m_waits == 0) begin
        if (m_wr && m_addr < 8'd16)
          m_regs[m_addr[3:0]] = (m_addr == 8'h0F) ? {5'b0, m_wdata[2:0]} : m_wdata;
        m_access = 1'b0;
        if (on && !enable) m_begin();
      end else if (!on) begin
        m_access = 1'b0;
      end else begin
        m_waits--;
      end
    end else if (m_setup) begin
      if (!on) m_setup = 1'b0;
      else if (enable) begin m_setup = 1'b0; m_access = 1'b1; end
    end else if (on && !enable) begin
      m_begin();
    end
  endfunction

  function automatic logic exp_ready();
    return m_access && (m_waits == 0);
  endfunction

  function automatic logic exp_err();
    return exp_ready() && (m_addr >= 8'd16);
  endfunction

  function automatic logic [7:0] exp_rdata();
    if (exp_ready() && !m_wr && m_addr < 8'd16) return m_regs[m_addr[3:0]];
    return 8'h00;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) m_reset();
    else m_step();
  end

  initial forever begin
    @(negedge clk);
    chk("ready", 32'(ready), 32'(exp_ready()));
    chk("err", 32'(err), 32'(exp_err()));
    chk("rdata", 32'(rdata), 32'(exp_rdata()));
  end

  // Runs one transfer; returns in the ready cycle (ncyc = access cycles used) or after an abort (ncyc = 0).
  // abort_at = 0 drops sel in SETUP, k > 0 drops it in access cycle k, negative never aborts.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d, input int abort_at,
                      input bit scramble, output logic [7:0] rd, output logic er, output int ncyc);
    rd = 8'h00; er = 1'b0; ncyc = 0;
    sel = ID; enable = 1'b0; write = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    if (abort_at == 0) begin
      sel = 2'd2; enable = 1'b0;
      @(posedge clk); #1;
      return;
    end
    enable = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 12; n++) begin
      if (ready) begin
        rd = rdata; er = err; ncyc = n;
        return;
      end
      if (n == abort_at) begin
        sel = 2'd2; enable = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (scramble) begin
        write = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL xfer_timeout actual=no ready required=ready within 12 access cycles at %0t", $time);
  endtask

  // Idle cycles; noisy mode shows other slaves' selects and enable-without-setup to the DUT.
  task automatic idle(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      if (noisy) begin
        sel    = 2'($urandom_range(0, 3));
        enable = (sel == ID) ? 1'b1 : 1'($urandom_range(0, 1));
        write  = 1'($urandom_range(0, 1));
        addr   = 8'($urandom);
      end else begin
        sel = 2'd0; enable = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         nc;
    int         sel_kind;
    logic [7:0] ra;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    reset = 1'b1;

    xfer(1'b1, 8'h03, 8'hA5, -1, 1'b0, rd, er, nc);
    chk("zw_write_cycles", 32'(nc), 32'd1);
    chk("zw_write_err", 32'(er), 32'h0);
    idle(1, 1'b0);
    xfer(1'b0, 8'h03, 8'h00, -1, 1'b0, rd, er, nc);
    chk("zw_read_data", 32'(rd), 32'hA5);
    idle(1, 1'b0);

    xfer(1'b1, 8'h0F, 8'h05, -1, 1'b0, rd, er, nc);
    chk("waitcfg_write_cycles", 32'(nc), 32'd1);
    idle(1, 1'b0);
    xfer(1'b0, 8'h03, 8'h00, -1, 1'b1, rd, er, nc);
    chk("wait5_read_cycles", 32'(nc), 32'd6);
    chk("wait5_read_data", 32'(rd), 32'hA5);
    idle(1, 1'b0);
    xfer(1'b1, 8'h0F, 8'hFB, -1, 1'b0, rd, er, nc);
    chk("waitcfg_old_n_cycles", 32'(nc), 32'd6);
    idle(1, 1'b0);
    xfer(1'b0, 8'h0F, 8'h00, -1, 1'b0, rd, er, nc);
    chk("waitcfg_new_n_cycles", 32'(nc), 32'd4);
    chk("waitcfg_read_masked", 32'(rd), 32'h03);
    idle(1, 1'b0);

    xfer(1'b1, 8'h20, 8'h77, -1, 1'b0, rd, er, nc);
    chk("unmapped_write_err", 32'(er), 32'h1);
    chk("unmapped_write_cycles", 32'(nc), 32'd4);
    idle(1, 1'b0);
    xfer(1'b0, 8'h20, 8'h00, -1, 1'b0, rd, er, nc);
    chk("unmapped_read_err", 32'(er), 32'h1);
    chk("unmapped_read_data", 32'(rd), 32'h00);
    idle(1, 1'b0);
    for (int a = 0; a < 15; a++) begin
      xfer(1'b0, 8'(a), 8'h00, -1, 1'b0, rd, er, nc);
      chk("unmapped_regs_intact", 32'(rd), (a == 3) ? 32'hA5 : 32'h00);
    end
    idle(1, 1'b0);

    xfer(1'b1, 8'h05, 8'h99, 2, 1'b0, rd, er, nc);
    chk("abort_no_ready", 32'(nc), 32'd0);
    chk("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
    idle(3, 1'b0);
    xfer(1'b0, 8'h05, 8'h00, -1, 1'b0, rd, er, nc);
    chk("abort_reg_unchanged", 32'(rd), 32'h00);

    xfer(1'b1, 8'h01, 8'h3C, -1, 1'b0, rd, er, nc);
    chk("rst_mid_ready_before", 32'(ready), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    chk("rst_mid_rdata", 32'(rdata), 32'h0);
    sel = 2'd0; enable = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b1;
    xfer(1'b0, 8'h01, 8'h00, -1, 1'b0, rd, er, nc);
    chk("rst_reg01_cleared", 32'(rd), 32'h00);
    chk("rst_waitcfg_cycles", 32'(nc), 32'd1);
    idle(1, 1'b0);
    xfer(1'b0, 8'h0F, 8'h00, -1, 1'b0, rd, er, nc);
    chk("rst_waitcfg_value", 32'(rd), 32'h00);
    idle(1, 1'b0);

    xfer(1'b1, 8'h02, 8'h11, -1, 1'b0, rd, er, nc);
    chk("b2b_write_cycles", 32'(nc), 32'd1);
    xfer(1'b0, 8'h02, 8'h00, -1, 1'b0, rd, er, nc);
    chk("b2b_read_data", 32'(rd), 32'h11);
    chk("b2b_read_cycles", 32'(nc), 32'd1);

    sel = ID; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("enable_in_idle", 32'(dut.state_q), 32'(IDLE));

    for (int t = 0; t < 300; t++) begin
      sel_kind = $urandom_range(0, 9);
      if (sel_kind < 7) ra = 8'($urandom_range(0, 14));
      else if (sel_kind == 7) ra = 8'h0F;
      else ra = 8'($urandom);
      xfer(1'($urandom_range(0, 1)), ra, 8'($urandom),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
           1'($urandom_range(0, 1)), rd, er, nc);
      if (nc == 0 || $urandom_range(0, 2) != 0)
        idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
